// File: rtl/input_conditioner_4.sv
// input_conditioner_4: synchronises and debounces two push-buttons and two
// selection switches for the segment editor. Buttons become one-cycle press
// pulses, and switches become debounced levels. A press pulse is dropped when
// it lands in the same cycle as a change of the debounced selection.
module input_conditioner_4 #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic btn_next_raw,
  input  logic btn_mode_raw,
  input  logic sw_h_raw,
  input  logic sw_l_raw,
  output logic next_segment_re,
  output logic change_mode_re,
  output logic sw_h_deb,
  output logic sw_l_deb
);

  // Channel order: 0 = btn_next, 1 = btn_mode, 2 = sw_h, 3 = sw_l.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  // The synchroniser carries the raw pin level, so its idle value is the raw
  // released level. The polarity flip is applied on the synchroniser output.
  // This is equivalent to inverting before synchronising, and it lets the
  // reset value of the chain be the raw inactive level.
  localparam logic [3:0] IDLE_LEVEL = {1'b0, 1'b0, BTN_IDLE, BTN_IDLE};
  localparam logic [3:0] INVERT     = {1'b0, 1'b0, BTN_IDLE, BTN_IDLE};

  logic [3:0]             raw;
  logic [SYNC_STAGES-1:0] sync_chain [4];
  logic [CW-1:0]          cnt        [4];
  logic [CW-1:0]          cnt_next   [4];
  logic [3:0]             q;
  logic [3:0]             q_next;
  logic [3:0]             lvl;
  logic [3:0]             settle;
  logic                   sel_change;

  assign raw = {sw_l_raw, sw_h_raw, btn_mode_raw, btn_next_raw};

  // Debounce next-state: count while the synchronised level disagrees with q,
  // and adopt the level once it has disagreed for DEBOUNCE_CYCLES edges.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl[i]      = sync_chain[i][SYNC_STAGES-1] ^ INVERT[i];
      settle[i]   = 1'b0;
      q_next[i]   = q[i];
      cnt_next[i] = '0;
      if (lvl[i] == q[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        settle[i]   = 1'b1;
        q_next[i]   = lvl[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
    // A selection change becomes visible at the same edge as any press that
    // settles now, so both are judged from this edge's settle events.
    sel_change = settle[2] | settle[3];
  end

  // State registers: synchronisers, debounce counters, stable levels and the
  // registered press pulses (rising settle only, gated by selection change).
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int i = 0; i < 4; i++) begin
        sync_chain[i] <= {SYNC_STAGES{IDLE_LEVEL[i]}};
        cnt[i]        <= '0;
      end
      q               <= 4'b0000;
      next_segment_re <= 1'b0;
      change_mode_re  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], raw[i]};
        cnt[i]        <= cnt_next[i];
      end
      q               <= q_next;
      next_segment_re <= settle[0] & lvl[0] & ~sel_change;
      change_mode_re  <= settle[1] & lvl[1] & ~sel_change;
    end
  end

  assign sw_h_deb = q[2];
  assign sw_l_deb = q[3];

endmodule

// File: tb/tb_input_conditioner_4.sv
// Directed bench for input_conditioner_4 with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1. Inputs change on the falling edge.
// Outputs are checked on the falling edge after each rising edge. A raw
// change made before edge k becomes visible after edge k+5. That is the 6th
// check after the change.
module tb_input_conditioner_4;

  logic clk = 1'b0;
  logic sync_reset;
  logic btn_next_raw;
  logic btn_mode_raw;
  logic sw_h_raw;
  logic sw_l_raw;
  logic next_segment_re;
  logic change_mode_re;
  logic sw_h_deb;
  logic sw_l_deb;

  int tests = 0;
  int fails = 0;

  input_conditioner_4 #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .btn_next_raw(btn_next_raw),
    .btn_mode_raw(btn_mode_raw),
    .sw_h_raw(sw_h_raw),
    .sw_l_raw(sw_l_raw),
    .next_segment_re(next_segment_re),
    .change_mode_re(change_mode_re),
    .sw_h_deb(sw_h_deb),
    .sw_l_deb(sw_l_deb)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n cycles. After each one, check all four outputs against the
  // expected constant levels.
  task automatic run(input int n, input logic en, input logic em,
                     input logic eh, input logic el, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "/next"}, next_segment_re, en);
      chk({tag, "/mode"}, change_mode_re, em);
      chk({tag, "/sw_h"}, sw_h_deb, eh);
      chk({tag, "/sw_l"}, sw_l_deb, el);
    end
  endtask

  initial begin
    // 1. Reset with buttons pressed and switches high.
    sync_reset   = 1'b1;
    btn_next_raw = 1'b0;
    btn_mode_raw = 1'b0;
    sw_h_raw     = 1'b1;
    sw_l_raw     = 1'b1;
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_first");
    run(2, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
    // Release reset with buttons idle. The switches rise 5 edges later.
    sync_reset   = 1'b0;
    btn_next_raw = 1'b1;
    btn_mode_raw = 1'b1;
    run(5, 1'b0, 1'b0, 1'b0, 1'b0, "rst_lat");
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "rst_sw_rise");
    run(3, 1'b0, 1'b0, 1'b1, 1'b1, "rst_sw_hold");

    // 2. Clean press of btn_next, held for 20 cycles, then a second press.
    btn_next_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "press1_lat");
    run(1, 1'b1, 1'b0, 1'b1, 1'b1, "press1_pulse");
    run(14, 1'b0, 1'b0, 1'b1, 1'b1, "press1_held");
    btn_next_raw = 1'b1;
    run(10, 1'b0, 1'b0, 1'b1, 1'b1, "release1");
    btn_next_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "press2_lat");
    run(1, 1'b1, 1'b0, 1'b1, 1'b1, "press2_pulse");
    run(4, 1'b0, 1'b0, 1'b1, 1'b1, "press2_held");
    btn_next_raw = 1'b1;
    run(8, 1'b0, 1'b0, 1'b1, 1'b1, "release2");

    // 3. Bouncing btn_mode: raw 0,1,0,0,1, then 0 from then on.
    btn_mode_raw = 1'b0;
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "bounce");
    btn_mode_raw = 1'b1;
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "bounce");
    btn_mode_raw = 1'b0;
    run(2, 1'b0, 1'b0, 1'b1, 1'b1, "bounce");
    btn_mode_raw = 1'b1;
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "bounce");
    btn_mode_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "bounce_lat");
    run(1, 1'b0, 1'b1, 1'b1, 1'b1, "bounce_pulse");
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "bounce_held");
    btn_mode_raw = 1'b1;
    run(10, 1'b0, 1'b0, 1'b1, 1'b1, "bounce_release");
    // A 3-cycle press glitch is rejected.
    btn_mode_raw = 1'b0;
    run(3, 1'b0, 1'b0, 1'b1, 1'b1, "glitch3");
    btn_mode_raw = 1'b1;
    run(10, 1'b0, 1'b0, 1'b1, 1'b1, "glitch3_after");

    // 4. Switch debounce: sw_l falls, then rises. A 2-cycle sw_h glitch is rejected.
    sw_l_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "swl_fall_lat");
    run(1, 1'b0, 1'b0, 1'b1, 1'b0, "swl_fall");
    run(2, 1'b0, 1'b0, 1'b1, 1'b0, "swl_low");
    sw_l_raw = 1'b1;
    run(5, 1'b0, 1'b0, 1'b1, 1'b0, "swl_rise_lat");
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "swl_rise");
    run(2, 1'b0, 1'b0, 1'b1, 1'b1, "swl_high");
    sw_h_raw = 1'b0;
    run(2, 1'b0, 1'b0, 1'b1, 1'b1, "swh_glitch");
    sw_h_raw = 1'b1;
    run(8, 1'b0, 1'b0, 1'b1, 1'b1, "swh_glitch_after");

    // 5. Suppression: the press settles in the same cycle that sw_l_deb rises.
    sw_l_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "sup_prep");
    run(3, 1'b0, 1'b0, 1'b1, 1'b0, "sup_prep_low");
    sw_l_raw     = 1'b1;
    btn_next_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b0, "sup_lat");
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "sup_dropped");
    run(10, 1'b0, 1'b0, 1'b1, 1'b1, "sup_not_reissued");
    btn_next_raw = 1'b1;
    run(8, 1'b0, 1'b0, 1'b1, 1'b1, "sup_release");
    // Same press one cycle after the switch change: the pulse goes through.
    sw_l_raw = 1'b0;
    run(5, 1'b0, 1'b0, 1'b1, 1'b1, "off_prep");
    run(3, 1'b0, 1'b0, 1'b1, 1'b0, "off_prep_low");
    sw_l_raw = 1'b1;
    run(1, 1'b0, 1'b0, 1'b1, 1'b0, "off_sw");
    btn_next_raw = 1'b0;
    run(4, 1'b0, 1'b0, 1'b1, 1'b0, "off_lat");
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, "off_sw_rise");
    run(1, 1'b1, 1'b0, 1'b1, 1'b1, "off_pulse");
    run(4, 1'b0, 1'b0, 1'b1, 1'b1, "off_held");
    btn_next_raw = 1'b1;
    run(8, 1'b0, 1'b0, 1'b1, 1'b1, "off_release");

    // 6. Reset at cnt=2 while btn_next is held. btn_mode and the switches
    //    change under reset. Both buttons remain held after reset is released.
    btn_next_raw = 1'b0;
    run(4, 1'b0, 1'b0, 1'b1, 1'b1, "mid_count");
    sync_reset   = 1'b1;
    btn_mode_raw = 1'b0;
    sw_h_raw     = 1'b0;
    sw_l_raw     = 1'b0;
    run(3, 1'b0, 1'b0, 1'b0, 1'b0, "mid_reset");
    sync_reset = 1'b0;
    run(5, 1'b0, 1'b0, 1'b0, 1'b0, "mid_full_lat");
    run(1, 1'b1, 1'b1, 1'b0, 1'b0, "mid_both_pulse");
    run(5, 1'b0, 1'b0, 1'b0, 1'b0, "mid_held");
    btn_next_raw = 1'b1;
    btn_mode_raw = 1'b1;
    run(8, 1'b0, 1'b0, 1'b0, 1'b0, "mid_release");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
